// File: rtl/roc_output_streamer_if.sv
// ---------------------------------------------------------------------------
// roc_output_streamer_if
// Groups the RoC-side inputs and UART-side outputs of roc_output_streamer.
//   i_tick        : RoC tick from the TPS divider (asynchronous)
//   i_en          : accept new ticks when high
//   i_roc_outputs : RoC output vector to snapshot
//   o_tx          : UART 8N1 serial out, idles high
//   o_busy        : frame transmission in progress
//   o_overrun     : sticky, a snapshot was dropped
// master = producer of the RoC side (host/core), slave = the streamer.
// ---------------------------------------------------------------------------
interface roc_output_streamer_if #(
    parameter int ROC_OUTPUTS = 8
) ();
    logic                   i_tick;
    logic                   i_en;
    logic [ROC_OUTPUTS-1:0] i_roc_outputs;
    logic                   o_tx;
    logic                   o_busy;
    logic                   o_overrun;

    modport master (
        output i_tick, i_en, i_roc_outputs,
        input  o_tx, o_busy, o_overrun
    );

    modport slave (
        input  i_tick, i_en, i_roc_outputs,
        output o_tx, o_busy, o_overrun
    );
endinterface

// File: rtl/roc_output_streamer.sv
// ---------------------------------------------------------------------------
// roc_output_streamer
// Snapshots the RoC output vector on every rising edge of the RoC tick and
// sends it over UART (8N1) as a frame: FRAME_HEADER followed by NB payload
// bytes, payload byte 0 = bits [7:0]. One active frame plus one pending
// snapshot are buffered; a third snapshot arriving while both are occupied is
// dropped and flags o_overrun.
// Ports:
//   i_clk : system clock
//   i_rst : synchronous active-low reset
//   io    : roc_output_streamer_if.slave (tick/enable/vector in, tx/busy/overrun out)
// ---------------------------------------------------------------------------
module roc_output_streamer #(
    parameter int          ROC_OUTPUTS  = 8,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  FRAME_HEADER = 8'hA5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    roc_output_streamer_if.slave   io
);
    localparam int NB  = (ROC_OUTPUTS + 7) >> 3;
    localparam int W   = NB * 8;
    localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [BW-1:0]        r_baud;
    logic [2:0]           r_bit;
    logic [BIW-1:0]       r_byte_idx;
    logic [7:0]           r_shift;
    logic [NB-1:0][7:0]   r_act;
    logic                 r_act_full;
    logic [W-1:0]         r_pend;
    logic                 r_pend_full;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overrun;

    logic                 w_pulse;
    logic                 w_accept;
    logic                 w_fsm_busy;
    logic                 w_bit_end;
    logic                 w_pend_vld;
    logic [W-1:0]         w_pend_val;
    logic [W-1:0]         w_snap;
    logic [7:0]           w_pay_byte;

    assign w_pulse    = r_sync[1] & ~r_prev;
    assign w_accept   = w_pulse & io.i_en;
    assign w_snap     = W'(io.i_roc_outputs);
    // Active register counts as occupied from the load until the frame ends,
    // including the single IDLE cycle before the start bit goes out.
    assign w_fsm_busy = (r_state != IDLE) || r_act_full;
    assign w_bit_end  = (r_baud == BW'(CLKS_PER_BIT - 1));
    // A snapshot accepted in the very cycle the last stop bit ends is promoted
    // straight away, so it must be visible to the byte-advance decision.
    assign w_pend_vld = r_pend_full | w_accept;
    assign w_pend_val = r_pend_full ? r_pend : w_snap;

    always_comb begin
        w_pay_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (r_byte_idx == BIW'(i)) w_pay_byte = r_act[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_sync      <= 2'b00;
            r_prev      <= 1'b0;
            r_baud      <= '0;
            r_bit       <= 3'd0;
            r_byte_idx  <= '0;
            r_shift     <= 8'hFF;
            r_act       <= '0;
            r_act_full  <= 1'b0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], io.i_tick};
            r_prev <= r_sync[1];

            if (w_accept) begin
                if (!w_fsm_busy) begin
                    r_act      <= w_snap;
                    r_act_full <= 1'b1;
                end else if (!r_pend_full) begin
                    r_pend      <= w_snap;
                    r_pend_full <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (r_act_full) begin
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift    <= FRAME_HEADER;
                        r_byte_idx <= '0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_byte_idx < BIW'(NB)) begin
                            r_shift    <= w_pay_byte;
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else if (w_pend_vld) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            r_act       <= w_pend_val;
                            r_pend_full <= 1'b0;
                            r_shift     <= FRAME_HEADER;
                            r_byte_idx  <= '0;
                            r_tx        <= 1'b0;
                            r_state     <= START;
                        end else begin
                            r_act_full <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.o_tx      = r_tx;
    assign io.o_busy    = r_busy;
    assign io.o_overrun = r_overrun;
endmodule
